alarm_code_entry: RTL and testbench

Keypad front end for the home alarm controller. Collects decimal keystrokes, validates the entered number, and drives the 5-bit `code` bus consumed by the alarm controller (31 = arm, 4 = disarm). Each accepted code is held for a fixed window, then the bus returns to the idle code. The block enforces inter-key timeout, failed-entry counting and a lockout period.

---
 rtl/alarm_pkg.sv | 24 ++
 rtl/alarm_timer.sv | 27 ++
 rtl/alarm_code_entry.sv | 159 +++++++++++++++
 tb/tb_alarm_code_entry.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm keypad front end: key encodings, code-bus values,
// the entry FSM state type and the code-acceptance rule.
package alarm_pkg;

   localparam logic [3:0] KEY_CLEAR = 4'd10;
   localparam logic [3:0] KEY_ENTER = 4'd11;

   localparam logic [4:0] CODE_ARM    = 5'd31;
   localparam logic [4:0] CODE_DISARM = 5'd4;
   localparam logic [4:0] CODE_IDLE   = 5'd0;

   typedef enum logic [1:0] {
      IDLE,
      ENTRY,
      HOLD,
      LOCKOUT
   } state_t;

   // Largest legal code is the arm code; an overflowed entry is never legal.
   function automatic logic code_ok(input logic [6:0] value, input logic overflow);
      return !overflow && (value <= {2'b00, CODE_ARM});
   endfunction

endpackage

// File: rtl/alarm_timer.sv
// Loadable down-counter shared by the timeout, hold and lockout phases.
// expired is high in the last cycle of a loaded interval, so a load of N ends N edges later.
module alarm_timer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         expired
);

   logic [W-1:0] count;

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (count != '0) begin
         count <= count - W'(1);
      end
   end

   assign expired = (count == W'(1));

endmodule

// File: rtl/alarm_code_entry.sv
// Keypad code entry: collects up to two decimal digits, validates them on ENTER and
// holds the accepted code on the bus, with inter-key timeout and failed-entry lockout.
module alarm_code_entry
   import alarm_pkg::*;
#(
   parameter int HOLD_CYCLES    = 16,
   parameter int TIMEOUT_CYCLES = 1000,
   parameter int MAX_FAILS      = 3,
   parameter int LOCKOUT_CYCLES = 5000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       key_valid,
   input  logic [3:0] key_code,
   output logic [4:0] code,
   output logic       code_valid,
   output logic       err,
   output logic       lockout
);

   localparam int MAX_AB  = (HOLD_CYCLES > TIMEOUT_CYCLES) ? HOLD_CYCLES : TIMEOUT_CYCLES;
   localparam int MAX_CYC = (MAX_AB > LOCKOUT_CYCLES) ? MAX_AB : LOCKOUT_CYCLES;
   localparam int TW      = $clog2(MAX_CYC) + 1;
   localparam int FW      = $clog2(MAX_FAILS + 1);

   state_t          state;
   logic [6:0]      acc;
   logic [1:0]      cnt;
   logic            ovf;
   logic [FW-1:0]   fails;
   logic [FW-1:0]   fails_inc;
   logic            is_digit;
   logic            entry_ok;
   logic            tmr_load;
   logic [TW-1:0]   tmr_val;
   logic            tmr_expired;

   assign is_digit  = (key_code <= 4'd9);
   assign entry_ok  = code_ok(acc, ovf);
   assign fails_inc = fails + FW'(1);

   // The one timer is reloaded with whichever interval the next state needs.
   always_comb begin
      tmr_load = 1'b0;
      tmr_val  = '0;
      case (state)
         IDLE: begin
            if (key_valid && is_digit) begin
               tmr_load = 1'b1;
               tmr_val  = TW'(TIMEOUT_CYCLES);
            end
         end
         ENTRY: begin
            if (key_valid) begin
               if (key_code == KEY_ENTER) begin
                  if (entry_ok) begin
                     tmr_load = 1'b1;
                     tmr_val  = TW'(HOLD_CYCLES);
                  end else if (fails_inc == FW'(MAX_FAILS)) begin
                     tmr_load = 1'b1;
                     tmr_val  = TW'(LOCKOUT_CYCLES);
                  end
               end else if (key_code != KEY_CLEAR) begin
                  tmr_load = 1'b1;
                  tmr_val  = TW'(TIMEOUT_CYCLES);
               end
            end
         end
         default: ;
      endcase
   end

   alarm_timer #(
      .W(TW)
   ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .load    (tmr_load),
      .load_val(tmr_val),
      .expired (tmr_expired)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         acc        <= '0;
         cnt        <= '0;
         ovf        <= 1'b0;
         fails      <= '0;
         code       <= CODE_IDLE;
         code_valid <= 1'b0;
         err        <= 1'b0;
         lockout    <= 1'b0;
      end else begin
         err <= 1'b0;
         case (state)
            IDLE: begin
               if (key_valid && is_digit) begin
                  acc   <= {3'b000, key_code};
                  cnt   <= 2'd1;
                  ovf   <= 1'b0;
                  state <= ENTRY;
               end
            end
            // A key in the expiry cycle wins over the timeout.
            ENTRY: begin
               if (key_valid) begin
                  if (is_digit) begin
                     if (cnt < 2'd2) begin
                        acc <= acc * 7'd10 + {3'b000, key_code};
                        cnt <= cnt + 2'd1;
                     end else begin
                        ovf <= 1'b1;
                     end
                  end else if (key_code == KEY_CLEAR) begin
                     acc   <= '0;
                     cnt   <= '0;
                     state <= IDLE;
                  end else if (key_code == KEY_ENTER) begin
                     if (entry_ok) begin
                        code       <= acc[4:0];
                        code_valid <= 1'b1;
                        fails      <= '0;
                        state      <= HOLD;
                     end else begin
                        err   <= 1'b1;
                        fails <= fails_inc;
                        if (fails_inc == FW'(MAX_FAILS)) begin
                           lockout <= 1'b1;
                           state   <= LOCKOUT;
                        end else begin
                           state <= IDLE;
                        end
                     end
                  end
               end else if (tmr_expired) begin
                  state <= IDLE;
               end
            end
            HOLD: begin
               if (tmr_expired) begin
                  code       <= CODE_IDLE;
                  code_valid <= 1'b0;
                  state      <= IDLE;
               end
            end
            LOCKOUT: begin
               if (tmr_expired) begin
                  lockout <= 1'b0;
                  fails   <= '0;
                  state   <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alarm_code_entry.sv
// Self-checking bench for alarm_code_entry: directed vector table, hand-written
// timeout/lockout/reset sequences, then random keystrokes against a deadline-based model.
module tb_alarm_code_entry;
   import alarm_pkg::*;

   localparam int HOLD    = 16;
   localparam int TIMEOUT = 1000;
   localparam int MAXF    = 3;
   localparam int LOCK    = 5000;
   localparam int RND_CYCLES = 20000;

   localparam int M_IDLE  = 0;
   localparam int M_ENTRY = 1;
   localparam int M_HOLD  = 2;
   localparam int M_LOCK  = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       key_valid = 1'b0;
   logic [3:0] key_code = 4'd0;
   logic [4:0] code;
   logic       code_valid;
   logic       err;
   logic       lockout;

   int checks = 0;
   int failures = 0;

   alarm_code_entry #(
      .HOLD_CYCLES   (HOLD),
      .TIMEOUT_CYCLES(TIMEOUT),
      .MAX_FAILS     (MAXF),
      .LOCKOUT_CYCLES(LOCK)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .key_valid (key_valid),
      .key_code  (key_code),
      .code      (code),
      .code_valid(code_valid),
      .err       (err),
      .lockout   (lockout)
   );

   always #5 clk = ~clk;

   // Reference model: the entry is a number built from decimal digits, and every
   // phase ends at an absolute edge number rather than via a counter.
   int now = 0;
   int m_state = M_IDLE;
   int m_val = 0;
   int m_digits = 0;
   bit m_ovf = 1'b0;
   int m_fails = 0;
   int m_deadline = 0;
   int e_code = 0;
   bit e_valid = 1'b0;
   bit e_err = 1'b0;
   bit e_lock = 1'b0;

   function automatic void modelEdge(input bit r, input bit kv, input int kc);
      now++;
      e_err = 1'b0;
      if (r) begin
         m_state = M_IDLE; m_val = 0; m_digits = 0; m_ovf = 1'b0; m_fails = 0;
         e_code = 0; e_valid = 1'b0; e_lock = 1'b0;
         return;
      end
      case (m_state)
         M_IDLE: if (kv && kc <= 9) begin
            m_val = kc; m_digits = 1; m_ovf = 1'b0;
            m_deadline = now + TIMEOUT; m_state = M_ENTRY;
         end
         M_ENTRY: if (kv) begin
            m_deadline = now + TIMEOUT;
            if (kc <= 9) begin
               if (m_digits < 2) begin
                  m_val = m_val * 10 + kc;
                  m_digits++;
               end else begin
                  m_ovf = 1'b1;
               end
            end else if (kc == 10) begin
               m_state = M_IDLE;
            end else if (kc == 11) begin
               if (!m_ovf && m_val <= 31) begin
                  e_code = m_val; e_valid = 1'b1; m_fails = 0;
                  m_deadline = now + HOLD; m_state = M_HOLD;
               end else begin
                  e_err = 1'b1;
                  m_fails++;
                  if (m_fails == MAXF) begin
                     e_lock = 1'b1; m_deadline = now + LOCK; m_state = M_LOCK;
                  end else begin
                     m_state = M_IDLE;
                  end
               end
            end
         end else if (now == m_deadline) begin
            m_state = M_IDLE;
         end
         M_HOLD: if (now == m_deadline) begin
            e_code = 0; e_valid = 1'b0; m_state = M_IDLE;
         end
         default: if (now == m_deadline) begin
            e_lock = 1'b0; m_fails = 0; m_state = M_IDLE;
         end
      endcase
   endfunction

   task automatic applyStimulus(input bit r, input bit kv, input logic [3:0] kc);
      rst = r;
      key_valid = kv;
      key_code = kc;
      @(posedge clk);
      modelEdge(r, kv, int'(kc));
      #1;
   endtask

   task automatic checkOne(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("[TB] FAIL %s: got %0d, expected %0d (edge %0d)", name, act, expv, now);
      end
   endtask

   task automatic checkOutput(input string name, input logic [4:0] ec, input bit ev,
                              input bit ee, input bit el);
      checkOne({name, ".code"}, 32'(code), 32'(ec));
      checkOne({name, ".code_valid"}, 32'(code_valid), 32'(ev));
      checkOne({name, ".err"}, 32'(err), 32'(ee));
      checkOne({name, ".lockout"}, 32'(lockout), 32'(el));
   endtask

   task automatic runIdle(input string name, input int n, input logic [4:0] ec,
                          input bit ev, input bit el);
      for (int i = 0; i < n; i++) begin
         applyStimulus(1'b0, 1'b0, 4'd0);
         checkOutput(name, ec, ev, 1'b0, el);
      end
   endtask

   task automatic pressKey(input string name, input logic [3:0] kc);
      applyStimulus(1'b0, 1'b1, kc);
      checkOutput(name, 5'd0, 1'b0, 1'b0, 1'b0);
   endtask

   // Ends with ENTER; checks the full hold window and the return to idle.
   task automatic acceptEntry(input string name, input logic [4:0] expc);
      applyStimulus(1'b0, 1'b1, KEY_ENTER);
      checkOutput(name, expc, 1'b1, 1'b0, 1'b0);
      runIdle(name, HOLD - 1, expc, 1'b1, 1'b0);
      runIdle(name, 1, 5'd0, 1'b0, 1'b0);
   endtask

   task automatic failEntry(input string name, input bit lock_exp);
      pressKey(name, 4'd9);
      pressKey(name, 4'd9);
      applyStimulus(1'b0, 1'b1, KEY_ENTER);
      checkOutput(name, 5'd0, 1'b0, 1'b1, lock_exp);
      runIdle(name, 1, 5'd0, 1'b0, lock_exp);
   endtask

   typedef struct {
      bit         r;
      bit         kv;
      logic [3:0] kc;
      int         reps;
      logic [4:0] ecode;
      bit         evalid;
      bit         eerr;
      bit         elock;
   } vec_t;

   vec_t vecs[$];

   task automatic addVec(input bit r, input bit kv, input logic [3:0] kc, input int reps,
                         input logic [4:0] ec, input bit ev, input bit ee, input bit el);
      vec_t v;
      v.r = r; v.kv = kv; v.kc = kc; v.reps = reps;
      v.ecode = ec; v.evalid = ev; v.eerr = ee; v.elock = el;
      vecs.push_back(v);
   endtask

   initial begin
      // Arm, with a key ignored during hold.
      addVec(1, 0, 4'd0, 1, 0, 0, 0, 0);
      addVec(0, 1, 4'd3, 1, 0, 0, 0, 0);
      addVec(0, 1, 4'd1, 1, 0, 0, 0, 0);
      addVec(0, 1, KEY_ENTER, 1, CODE_ARM, 1, 0, 0);
      addVec(0, 1, 4'd5, 1, CODE_ARM, 1, 0, 0);
      addVec(0, 0, 4'd0, 14, CODE_ARM, 1, 0, 0);
      addVec(0, 0, 4'd0, 1, 0, 0, 0, 0);
      // Disarm "04", then "4" keyed in the first cycle after hold.
      addVec(0, 1, 4'd0, 1, 0, 0, 0, 0);
      addVec(0, 1, 4'd4, 1, 0, 0, 0, 0);
      addVec(0, 1, KEY_ENTER, 1, CODE_DISARM, 1, 0, 0);
      addVec(0, 0, 4'd0, 15, CODE_DISARM, 1, 0, 0);
      addVec(0, 0, 4'd0, 1, 0, 0, 0, 0);
      addVec(0, 1, 4'd4, 1, 0, 0, 0, 0);
      addVec(0, 1, KEY_ENTER, 1, CODE_DISARM, 1, 0, 0);
      addVec(0, 0, 4'd0, 15, CODE_DISARM, 1, 0, 0);
      addVec(0, 0, 4'd0, 1, 0, 0, 0, 0);
      // Out of range "32", overflow "123", then "5" clears the fail count.
      addVec(0, 1, 4'd3, 1, 0, 0, 0, 0);
      addVec(0, 1, 4'd2, 1, 0, 0, 0, 0);
      addVec(0, 1, KEY_ENTER, 1, 0, 0, 1, 0);
      addVec(0, 0, 4'd0, 1, 0, 0, 0, 0);
      addVec(0, 1, 4'd1, 1, 0, 0, 0, 0);
      addVec(0, 1, 4'd2, 1, 0, 0, 0, 0);
      addVec(0, 1, 4'd3, 1, 0, 0, 0, 0);
      addVec(0, 1, KEY_ENTER, 1, 0, 0, 1, 0);
      addVec(0, 0, 4'd0, 1, 0, 0, 0, 0);
      addVec(0, 1, 4'd5, 1, 0, 0, 0, 0);
      addVec(0, 1, KEY_ENTER, 1, 5'd5, 1, 0, 0);
      addVec(0, 0, 4'd0, 15, 5'd5, 1, 0, 0);
      addVec(0, 0, 4'd0, 1, 0, 0, 0, 0);
      // Code 0 is emitted with code_valid.
      addVec(0, 1, 4'd0, 1, 0, 0, 0, 0);
      addVec(0, 1, KEY_ENTER, 1, 0, 1, 0, 0);
      addVec(0, 0, 4'd0, 15, 0, 1, 0, 0);
      addVec(0, 0, 4'd0, 1, 0, 0, 0, 0);
      // Non-digits in IDLE do nothing; ignored code inside an entry keeps acc.
      addVec(0, 1, KEY_ENTER, 1, 0, 0, 0, 0);
      addVec(0, 1, KEY_CLEAR, 1, 0, 0, 0, 0);
      addVec(0, 1, 4'd13, 1, 0, 0, 0, 0);
      addVec(0, 1, 4'd1, 1, 0, 0, 0, 0);
      addVec(0, 1, 4'd12, 1, 0, 0, 0, 0);
      addVec(0, 1, 4'd7, 1, 0, 0, 0, 0);
      addVec(0, 1, KEY_ENTER, 1, 5'd17, 1, 0, 0);
      addVec(0, 0, 4'd0, 15, 5'd17, 1, 0, 0);
      addVec(0, 0, 4'd0, 1, 0, 0, 0, 0);
      // CLEAR discards the pending digit.
      addVec(0, 1, 4'd2, 1, 0, 0, 0, 0);
      addVec(0, 1, KEY_CLEAR, 1, 0, 0, 0, 0);
      addVec(0, 1, 4'd4, 1, 0, 0, 0, 0);
      addVec(0, 1, KEY_ENTER, 1, CODE_DISARM, 1, 0, 0);
      addVec(0, 0, 4'd0, 15, CODE_DISARM, 1, 0, 0);
      addVec(0, 0, 4'd0, 1, 0, 0, 0, 0);

      $display("[TB] directed vectors");
      foreach (vecs[k]) begin
         for (int j = 0; j < vecs[k].reps; j++) begin
            applyStimulus(vecs[k].r, vecs[k].kv, vecs[k].kc);
            checkOutput($sformatf("vec%0d", k), vecs[k].ecode, vecs[k].evalid,
                        vecs[k].eerr, vecs[k].elock);
         end
      end

      $display("[TB] lockout sequence");
      failEntry("lock_f1", 1'b0);
      failEntry("lock_f2", 1'b0);
      failEntry("lock_f3", 1'b1);
      for (int i = 0; i < LOCK - 2; i++) begin
         applyStimulus(1'b0, i < 3, (i == 0) ? 4'd3 : (i == 1) ? 4'd1 : KEY_ENTER);
         checkOutput("lock_hold", 5'd0, 1'b0, 1'b0, 1'b1);
      end
      runIdle("lock_end", 1, 5'd0, 1'b0, 1'b0);
      pressKey("lock_after", 4'd3);
      pressKey("lock_after", 4'd1);
      acceptEntry("lock_after", CODE_ARM);

      $display("[TB] timeout sequences");
      pressKey("to_a", 4'd3);
      runIdle("to_a", TIMEOUT, 5'd0, 1'b0, 1'b0);
      pressKey("to_a", 4'd1);
      acceptEntry("to_a", 5'd1);
      pressKey("to_b", 4'd3);
      runIdle("to_b", TIMEOUT - 2, 5'd0, 1'b0, 1'b0);
      pressKey("to_b", 4'd12);
      runIdle("to_b", TIMEOUT - 2, 5'd0, 1'b0, 1'b0);
      pressKey("to_b", 4'd1);
      acceptEntry("to_b", CODE_ARM);

      $display("[TB] reset sequences");
      pressKey("rst_hold", 4'd3);
      pressKey("rst_hold", 4'd1);
      applyStimulus(1'b0, 1'b1, KEY_ENTER);
      checkOutput("rst_hold", CODE_ARM, 1'b1, 1'b0, 1'b0);
      runIdle("rst_hold", 3, CODE_ARM, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0, 4'd0);
      checkOutput("rst_hold_after", 5'd0, 1'b0, 1'b0, 1'b0);
      failEntry("rst_lock", 1'b0);
      failEntry("rst_lock", 1'b0);
      failEntry("rst_lock", 1'b1);
      runIdle("rst_lock", 10, 5'd0, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b0, 4'd0);
      checkOutput("rst_lock_after", 5'd0, 1'b0, 1'b0, 1'b0);
      pressKey("rst_lock_entry", 4'd3);
      pressKey("rst_lock_entry", 4'd1);
      acceptEntry("rst_lock_entry", CODE_ARM);
      failEntry("rst_fails", 1'b0);
      failEntry("rst_fails", 1'b0);
      applyStimulus(1'b1, 1'b0, 4'd0);
      checkOutput("rst_fails", 5'd0, 1'b0, 1'b0, 1'b0);
      failEntry("rst_fails_post", 1'b0);
      failEntry("rst_fails_post", 1'b0);
      pressKey("rst_fails_post", 4'd4);
      acceptEntry("rst_fails_post", CODE_DISARM);

      $display("[TB] random stimulus");
      applyStimulus(1'b1, 1'b0, 4'd0);
      checkOutput("rnd_rst", 5'(e_code), e_valid, e_err, e_lock);
      for (int i = 0; i < RND_CYCLES; i++) begin
         bit         r;
         bit         kv;
         logic [3:0] kc;
         int         sel;
         int         gap;
         if ($urandom_range(0, 399) == 0) begin
            gap = $urandom_range(TIMEOUT - 3, TIMEOUT + 2);
            for (int g = 0; g < gap; g++) begin
               applyStimulus(1'b0, 1'b0, 4'd0);
               checkOutput("rnd_gap", 5'(e_code), e_valid, e_err, e_lock);
            end
         end
         r = ($urandom_range(0, 599) == 0);
         kv = ($urandom_range(0, 9) < 6);
         sel = $urandom_range(0, 99);
         if (sel < 35)      kc = 4'($urandom_range(0, 3));
         else if (sel < 65) kc = 4'($urandom_range(0, 9));
         else if (sel < 82) kc = KEY_ENTER;
         else if (sel < 90) kc = KEY_CLEAR;
         else               kc = 4'($urandom_range(12, 15));
         applyStimulus(r, kv, kc);
         checkOutput("rnd", 5'(e_code), e_valid, e_err, e_lock);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
